// File: rtl/adder_result_serializer.sv
// Serializes one {cout, sum} adder result per handshake onto a single wire:
// start bit, data LSB first, even parity, stop bit, each held BIT_CYCLES clocks.
module adder_result_serializer #(
  parameter int WIDTH      = 4,
  parameter int BIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             cout,
  input  logic [WIDTH-1:0] sum,
  output logic             in_ready,
  output logic             tx,
  output logic             busy,
  output logic             done,
  output logic [7:0]       frame_cnt
);
  localparam int CW = $clog2(BIT_CYCLES) + 1;
  localparam int IW = (WIDTH + 1 > 1) ? $clog2(WIDTH + 1) : 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(BIT_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(WIDTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state;
  logic [WIDTH:0]  word;
  logic            par;
  logic [CW-1:0]   bit_cnt;
  logic [IW-1:0]   bit_idx;
  logic [IW-1:0]   nxt_idx;

  assign in_ready = (state == IDLE);
  assign nxt_idx  = bit_idx + IW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tx        <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= 8'd0;
      word      <= '0;
      par       <= 1'b0;
      bit_cnt   <= '0;
      bit_idx   <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (in_valid) begin
          word    <= {cout, sum};
          par     <= ^{cout, sum};
          state   <= START;
          tx      <= 1'b0;
          busy    <= 1'b1;
          bit_cnt <= CNT_RELOAD;
        end
      end else if (bit_cnt != '0) begin
        bit_cnt <= bit_cnt - CW'(1);
      end else begin
        // bit-period boundary: reload and present the next line value
        bit_cnt <= CNT_RELOAD;
        case (state)
          START: begin
            state   <= DATA;
            bit_idx <= '0;
            tx      <= word[0];
          end
          DATA: begin
            if (bit_idx == LAST_IDX) begin
              state <= PARITY;
              tx    <= par;
            end else begin
              bit_idx <= nxt_idx;
              tx      <= word[nxt_idx];
            end
          end
          PARITY: begin
            state <= STOP;
            tx    <= 1'b1;
          end
          STOP: begin
            state     <= IDLE;
            tx        <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
            frame_cnt <= frame_cnt + 8'd1;
          end
          default: begin
            state <= IDLE;
            tx    <= 1'b1;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: doc/adder_result_serializer.md
# adder_result_serializer

Downstream stage of the registered parameterised adder. Accepts one `{cout, sum}` result word per handshake and transmits it on a single-bit line as a framed serial word: start bit, data LSB first, even parity, stop bit. Provides a busy/ready handshake, a one-cycle completion pulse, and a wrapping count of frames sent. Used to stream adder results off-block over one wire.

## Interface

- `WIDTH`, default 4: width of `sum`. The transmitted data word is WIDTH+1 bits, with `cout` as the MSB.
- `BIT_CYCLES`, default 2: clock cycles each serial bit is held. Legal range is ≥1.
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: `cout`/`sum` hold a result to send.
- `cout`, input, 1: adder carry-out; becomes data MSB.
- `sum`, input, WIDTH: adder sum; `sum[0]` is transmitted first.
- `in_ready`, output, 1: high when the block can accept a word (state IDLE). Combinational from state.
- `tx`, output, 1: serial line, registered, idles high.
- `busy`, output, 1: high while a frame is in progress (any state other than IDLE). Registered.
- `done`, output, 1: one-cycle pulse in the cycle after the stop bit completes. Registered.
- `frame_cnt`, output, 8: number of frames completed, wraps 255→0. Registered.

## Operation

- **Reset values:** `tx`=1, `busy`=0, `done`=0, `frame_cnt`=0, state=IDLE, `in_ready`=1.
  - Reset has priority over every other event.
  - Reset during a frame aborts it: `tx`=1 after the reset edge, no `done` pulse, `frame_cnt` cleared.
- **Accept:** at a rising edge with `in_valid`=1 and `in_ready`=1:
  - Latch `word = {cout, sum}` and compute `par = ^word`, so the total count of 1s across data+parity is even.
  - Go to START and drive `tx`=0.
  - `in_valid` while busy is ignored. There is no queueing and no error flag; upstream must hold `in_valid` until `in_ready`.
- **States:** IDLE → START → DATA → PARITY → STOP → IDLE.
  - **START:** `tx`=0 for BIT_CYCLES cycles.
  - **DATA:** `tx` = `word[i]` for i = 0..WIDTH, each held BIT_CYCLES cycles. The bit index increments on each bit-period boundary.
  - **PARITY:** `tx`=`par` for BIT_CYCLES cycles.
  - **STOP:** `tx`=1 for BIT_CYCLES cycles.
- **Frame completion:** at the edge ending STOP:
  - Go to IDLE, set `done`=1 for one cycle, and increment `frame_cnt` modulo 256.
- **Counters and rules:**
  - The bit-period counter is ceil(log2(BIT_CYCLES))+1 bits wide and reloads at every bit boundary. With BIT_CYCLES=1 each bit lasts exactly one cycle.
  - The data bit index needs ceil(log2(WIDTH+1)) bits.
  - The latched word is stable for the whole frame. Input changes after accept do not affect the frame.

## Timing

- Accept at edge k: `tx`=0 and `busy`=1 are visible from edge k.
- Frame length is (WIDTH+4)·BIT_CYCLES cycles. With defaults that is 16 cycles: `tx` is low from edge k to edge k+2, and the stop bit ends at edge k+16.
- `done`=1, `busy`=0 and `in_ready`=1 during the cycle after edge k+16.
  - If `in_valid` is high in that cycle, the next frame starts at edge k+17 (`tx`=0).
  - Back-to-back frames therefore have 1 idle-high cycle between the stop bit and the next start bit.
- `frame_cnt` is updated on the same edge that raises `done`.

## Test plan

- **Reset:** hold `rst`=1 for 2 cycles with `in_valid`=1 → `tx`=1, `busy`=0, `done`=0, `frame_cnt`=0, `in_ready`=1, and no frame starts.
- **Single frame, defaults:** `sum`=4'b1011, `cout`=1 (word 5'b11011, par=0) → `tx` per 2-cycle bit is 0,1,1,0,1,1,0,1. `done` pulses once after 16 cycles and `frame_cnt`=1.
- **Odd parity word:** `sum`=4'b0001, `cout`=0 → data bits 1,0,0,0,0, parity bit 1, and the stop bit is 1.
- **Ignore while busy:** change `sum`/`cout` and hold `in_valid`=1 throughout a frame → the frame carries the originally latched word. A second frame starts exactly 1 cycle after `done`.
- **Reset mid-frame:** assert `rst` at cycle 7 of a frame → `tx`=1 on the next edge, no `done` pulse, `frame_cnt`=0, and a new accept works immediately after.
- **Wrap and scoreboard:** send 256 frames with random `a`+`b`+`cin` results, with BIT_CYCLES=1 → every deserialized word and parity matches, and `frame_cnt` reads 0 after frame 256.
